// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// load_store_unit_pkg : load/store kind encodings, FSM states, lane helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

   localparam logic [2:0] LD_LB      = 3'b000;
   localparam logic [2:0] LD_LH      = 3'b001;
   localparam logic [2:0] LD_LW      = 3'b010;
   localparam logic [2:0] LD_LBU     = 3'b100;
   localparam logic [2:0] LD_LHU     = 3'b101;
   localparam logic [2:0] LD_NOTLOAD = 3'b111;

   localparam logic [1:0] ST_SB       = 2'b00;
   localparam logic [1:0] ST_SH       = 2'b01;
   localparam logic [1:0] ST_SW       = 2'b10;
   localparam logic [1:0] ST_NOTSTORE = 2'b11;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } lsu_state_e;

   // Codes 011 and 110 are reserved and decode as "no load".
   function automatic logic is_load_kind(input logic [2:0] kind);
      return (kind == LD_LB) || (kind == LD_LH) || (kind == LD_LW) ||
             (kind == LD_LBU) || (kind == LD_LHU);
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] kind, input logic [1:0] lo);
      case (kind)
         ST_SB:   return 4'b0001 << lo;
         ST_SH:   return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [1:0] kind, input logic [31:0] d);
      case (kind)
         ST_SB:   return {4{d[7:0]}};
         ST_SH:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
// ============================================================================
// load_extend : byte/half lane select with sign/zero extension of read data
// Rev 1.0
// ============================================================================
`default_nettype none

module load_extend
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  info_load,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (info_load)
         LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  data = {24'd0, byte_sel};
         LD_LH:   data = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : single-outstanding req/ack memory stage with load extension
// Optional feature macro: LSU_MISALIGN_TRAP_EN (reject misaligned half/word)
// Rev 1.0
// ============================================================================
`default_nettype none

module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [2:0]  info_load,
   input  logic [1:0]  info_store,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [4:0]  dstreg_num,
   output logic        ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic        misalign_err
);

   lsu_state_e  state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [2:0]  ld_kind_q, ld_kind_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [4:0]  dst_q, dst_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_reg_q, wb_reg_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        misalign_err_q, misalign_err_d;

   logic        is_load;
   logic        is_store;
   logic        misaligned;
   logic [31:0] load_data;

   load_extend u_load_extend (
      .rdata     (mem_rdata),
      .addr_lo   (addr_lo_q),
      .info_load (ld_kind_q),
      .data      (load_data)
   );

   always_comb begin
      is_load  = is_load_kind(info_load);
      is_store = !is_load && (info_store != ST_NOTSTORE);
`ifdef LSU_MISALIGN_TRAP_EN
      if (is_load)
         misaligned = (((info_load == LD_LH) || (info_load == LD_LHU)) && addr[0]) ||
                      ((info_load == LD_LW) && (addr[1:0] != 2'b00));
      else
         misaligned = ((info_store == ST_SH) && addr[0]) ||
                      ((info_store == ST_SW) && (addr[1:0] != 2'b00));
`else
      misaligned = 1'b0;
`endif
   end

   always_comb begin
      state_d        = state_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_be_d       = mem_be_q;
      mem_wdata_d    = mem_wdata_q;
      ld_kind_d      = ld_kind_q;
      addr_lo_d      = addr_lo_q;
      dst_d          = dst_q;
      wb_valid_d     = 1'b0;
      wb_reg_d       = wb_reg_q;
      wb_data_d      = wb_data_q;
      misalign_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid && (is_load || is_store)) begin
               if (misaligned) begin
                  misalign_err_d = 1'b1;
               end else begin
                  state_d     = S_ACCESS;
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_be_d    = is_load ? 4'b1111 : store_be(info_store, addr[1:0]);
                  mem_wdata_d = is_load ? 32'd0 : store_wdata(info_store, store_data);
                  ld_kind_d   = info_load;
                  addr_lo_d   = addr[1:0];
                  dst_d       = dstreg_num;
               end
            end
         end
         default: begin
            if (mem_ack) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (!mem_we_q) begin
                  wb_valid_d = 1'b1;
                  wb_reg_d   = dst_q;
                  wb_data_d  = load_data;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= 32'd0;
         mem_be_q       <= 4'd0;
         mem_wdata_q    <= 32'd0;
         ld_kind_q      <= LD_NOTLOAD;
         addr_lo_q      <= 2'd0;
         dst_q          <= 5'd0;
         wb_valid_q     <= 1'b0;
         wb_reg_q       <= 5'd0;
         wb_data_q      <= 32'd0;
         misalign_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_be_q       <= mem_be_d;
         mem_wdata_q    <= mem_wdata_d;
         ld_kind_q      <= ld_kind_d;
         addr_lo_q      <= addr_lo_d;
         dst_q          <= dst_d;
         wb_valid_q     <= wb_valid_d;
         wb_reg_q       <= wb_reg_d;
         wb_data_q      <= wb_data_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   assign ready        = (state_q == S_IDLE);
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_be       = mem_be_q;
   assign mem_wdata    = mem_wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_reg       = wb_reg_q;
   assign wb_data      = wb_data_q;
   assign misalign_err = misalign_err_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : directed vector table, hand corner sequences and a
// randomized run against a behavioural model of the load/store rules.
// ============================================================================
`default_nettype none

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  info_load = 3'b111;
   logic [1:0]  info_store = 2'b11;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic [4:0]  dstreg_num = '0;
   logic        ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        misalign_err;

   int n_checks = 0;
   int n_pass   = 0;

   load_store_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .info_load    (info_load),
      .info_store   (info_store),
      .addr         (addr),
      .store_data   (store_data),
      .dstreg_num   (dstreg_num),
      .ready        (ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_be       (mem_be),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .wb_valid     (wb_valid),
      .wb_reg       (wb_reg),
      .wb_data      (wb_data),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        issue;
      logic        err;
      logic        we;
      logic        is_ld;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] wbd;
   } exp_t;

   typedef struct {
      logic [2:0]  ld;
      logic [1:0]  st;
      logic [31:0] a;
      logic [31:0] sd;
      logic [4:0]  dst;
      logic [31:0] rd;
      int          dly;
      exp_t        e;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Behavioural model: lane arithmetic straight from the access rules.
   function automatic exp_t model(input logic [2:0] ld, input logic [1:0] st,
                                  input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] rd);
      exp_t e;
      int   off;
      int   size;
      logic sgn;
      logic [31:0] v;
      off = int'(a % 4);
      e.is_ld = (ld == 3'd0) || (ld == 3'd1) || (ld == 3'd2) || (ld == 3'd4) || (ld == 3'd5);
      e.we    = !e.is_ld && (st != 2'd3);
      e.issue = e.is_ld || e.we;
      if (e.is_ld) size = (ld == 3'd2) ? 4 : ((ld == 3'd1 || ld == 3'd5) ? 2 : 1);
      else         size = (st == 2'd2) ? 4 : ((st == 2'd1) ? 2 : 1);
      e.err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (e.issue && (off % size) != 0) begin
         e.err   = 1'b1;
         e.issue = 1'b0;
      end
`endif
      e.be = 4'hF;
      e.wdata = 32'd0;
      e.wbd = 32'd0;
      if (e.we) begin
         if (size == 1) begin
            e.be = 4'(1 << off);
            e.wdata = (sd & 32'hFF) * 32'h01010101;
         end else if (size == 2) begin
            e.be = (off >= 2) ? 4'hC : 4'h3;
            e.wdata = (sd & 32'hFFFF) * 32'h00010001;
         end else begin
            e.wdata = sd;
         end
      end
      if (e.is_ld) begin
         sgn = (ld == 3'd0) || (ld == 3'd1);
         if (size == 1) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
         end else if (size == 2) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
         end else begin
            v = rd;
         end
         e.wbd = v;
      end
      return e;
   endfunction

   // Starts and ends #1 after a rising edge with the DUT idle.
   task automatic run_txn(input string tag, input logic [2:0] ld, input logic [1:0] st,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] dst,
                          input logic [31:0] rd, input int dly, input exp_t e);
      logic [31:0] prev_wbd;
      logic [4:0]  prev_reg;
      prev_wbd = wb_data;
      prev_reg = wb_reg;
      req_valid = 1'b1; info_load = ld; info_store = st; addr = a;
      store_data = sd; dstreg_num = dst;
      @(posedge clk); #1;
      req_valid = 1'b0; info_load = 3'b111; info_store = 2'b11;
      addr = $urandom; store_data = $urandom; dstreg_num = 5'($urandom);
      chk({tag, " mem_req"}, 32'(mem_req), 32'(e.issue));
      chk({tag, " ready"}, 32'(ready), 32'(!e.issue));
      chk({tag, " misalign_err"}, 32'(misalign_err), 32'(e.err));
      if (!e.issue) begin
         @(posedge clk); #1;
         chk({tag, " no wb_valid"}, 32'(wb_valid), 32'd0);
         chk({tag, " err pulse ends"}, 32'(misalign_err), 32'd0);
         chk({tag, " stays idle"}, 32'(mem_req), 32'd0);
         return;
      end
      chk({tag, " mem_we"}, 32'(mem_we), 32'(e.we));
      chk({tag, " mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
      chk({tag, " mem_be"}, 32'(mem_be), 32'(e.be));
      if (e.we) chk({tag, " mem_wdata"}, mem_wdata, e.wdata);
      for (int i = 0; i < dly; i++) begin
         @(posedge clk); #1;
         chk({tag, " hold mem_req"}, 32'(mem_req), 32'd1);
         chk({tag, " hold mem_be"}, 32'(mem_be), 32'(e.be));
      end
      mem_ack = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      chk({tag, " ready after ack"}, 32'(ready), 32'd1);
      chk({tag, " mem_req drop"}, 32'(mem_req), 32'd0);
      chk({tag, " wb_valid"}, 32'(wb_valid), 32'(e.is_ld));
      if (e.is_ld) begin
         chk({tag, " wb_reg"}, 32'(wb_reg), 32'(dst));
         chk({tag, " wb_data"}, wb_data, e.wbd);
      end
      @(posedge clk); #1;
      chk({tag, " wb pulse ends"}, 32'(wb_valid), 32'd0);
      chk({tag, " wb_data hold"}, wb_data, e.is_ld ? e.wbd : prev_wbd);
      chk({tag, " wb_reg hold"}, 32'(wb_reg), e.is_ld ? 32'(dst) : 32'(prev_reg));
   endtask

   vec_t vecs[11];

   initial begin
      exp_t e;
      logic [2:0] rld;
      logic [1:0] rst_k;
      logic [31:0] ra;

      vecs[0]  = '{3'b111, 2'b10, 32'h100, 32'hDEADBEEF, 5'd0, 32'h0, 2,
                   '{1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0}};
      vecs[1]  = '{3'b111, 2'b00, 32'h103, 32'h000000A5, 5'd0, 32'h0, 0,
                   '{1'b1, 1'b0, 1'b1, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h0}};
      vecs[2]  = '{3'b000, 2'b11, 32'h101, 32'h0, 5'd5, 32'h12348056, 1,
                   '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0, 32'hFFFFFF80}};
      vecs[3]  = '{3'b100, 2'b11, 32'h101, 32'h0, 5'd5, 32'h12348056, 0,
                   '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0, 32'h00000080}};
      vecs[4]  = '{3'b101, 2'b11, 32'h102, 32'h0, 5'd9, 32'h80010000, 0,
                   '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0, 32'h00008001}};
      vecs[5]  = '{3'b001, 2'b11, 32'h102, 32'h0, 5'd10, 32'h80010000, 3,
                   '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0, 32'hFFFF8001}};
      vecs[6]  = '{3'b111, 2'b01, 32'h102, 32'h1234BEEF, 5'd0, 32'h0, 0,
                   '{1'b1, 1'b0, 1'b1, 1'b0, 4'hC, 32'hBEEFBEEF, 32'h0}};
      vecs[7]  = '{3'b010, 2'b11, 32'h104, 32'h0, 5'd31, 32'hCAFEF00D, 0,
                   '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D}};
      vecs[8]  = '{3'b000, 2'b10, 32'h100, 32'h11223344, 5'd7, 32'h000000FF, 0,
                   '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0, 32'hFFFFFFFF}};
      vecs[9]  = '{3'b111, 2'b11, 32'h100, 32'h0, 5'd1, 32'h0, 0,
                   '{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0}};
      vecs[10] = '{3'b011, 2'b11, 32'h100, 32'h0, 5'd1, 32'h0, 0,
                   '{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0}};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", 32'(ready), 32'd1);
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset mem_be", 32'(mem_be), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset wb_valid", 32'(wb_valid), 32'd0);
      chk("reset wb_data", wb_data, 32'd0);
      chk("reset misalign_err", 32'(misalign_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i])
         run_txn($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].a, vecs[i].sd,
                 vecs[i].dst, vecs[i].rd, vecs[i].dly, vecs[i].e);

      // Misaligned word load: issued normally or trapped depending on build
      e = model(3'b010, 2'b11, 32'h102, 32'h0, 32'h55667788);
      run_txn("lw_misalign", 3'b010, 2'b11, 32'h102, 32'h0, 5'd3, 32'h55667788, 0, e);

      // Ack while idle is ignored
      mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("idle ack wb_valid", 32'(wb_valid), 32'd0);
      chk("idle ack ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      chk("idle ack no late wb", 32'(wb_valid), 32'd0);

      // Reset in the middle of an access
      req_valid = 1'b1; info_load = 3'b010; info_store = 2'b11; addr = 32'h200;
      dstreg_num = 5'd4;
      @(posedge clk); #1;
      req_valid = 1'b0; info_load = 3'b111;
      chk("abort mem_req before", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort mem_req async", 32'(mem_req), 32'd0);
      chk("abort ready async", 32'(ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("abort no wb_valid", 32'(wb_valid), 32'd0);
      chk("abort ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      chk("abort no late wb", 32'(wb_valid), 32'd0);
      chk("abort mem_req low", 32'(mem_req), 32'd0);

      // Randomized transactions against the model
      for (int n = 0; n < 60; n++) begin
         logic [31:0] rsd;
         logic [31:0] rrd;
         rld   = 3'($urandom_range(0, 7));
         rst_k = 2'($urandom_range(0, 3));
         ra    = $urandom;
         rsd   = $urandom;
         rrd   = $urandom;
         e = model(rld, rst_k, ra, rsd, rrd);
         run_txn($sformatf("rand%0d", n), rld, rst_k, ra, rsd, 5'($urandom), rrd,
                 int'($urandom_range(0, 3)), e);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage that consumes the decoder's load/store control encoding (`info_load`, `info_store`, `dstreg_num`), together with the ALU-computed effective address and the rs2 store data. It issues one word-aligned request at a time on a req/ack data-memory port and generates byte enables and replicated write data. Load results are returned aligned and sign- or zero-extended for register writeback. It sits between execute and writeback and stalls the pipeline while an access is outstanding.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: a decoded instruction is presented this cycle.
- `info_load` in 3: load kind. LB=000, LH=001, LW=010, LBU=100, LHU=101, NOTLOAD=111.
- `info_store` in 2: store kind. SB=00, SH=01, SW=10, NOTSTORE=11.
- `addr` in 32: effective address (rs1+imm).
- `store_data` in 32: rs2 value.
- `dstreg_num` in 5: load destination register.
- `ready` out 1: block can accept an access.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1=write.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `mem_ack` in 1: access complete.
- `wb_valid` out 1: one-cycle pulse, load result valid.
- `wb_reg` out 5: destination register.
- `wb_data` out 32: extended load result.
- `misalign_err` out 1: one-cycle pulse, misaligned access rejected (macro only).

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: `ready`=1. Accept when `req_valid` and (`info_load`≠NOTLOAD or `info_store`≠NOTSTORE). On accept, register address, kind, data and `dstreg_num`, then go to ACCESS.
- If both load and store kinds are valid, the load takes priority and the store is ignored. If neither is valid, nothing happens.
- Unknown `info_load` code (011, 110) is treated as NOTLOAD.
- ACCESS: `mem_req`=1. `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` hold stable until `mem_ack`. On `mem_ack`, return to IDLE. For loads, capture `mem_rdata` into `wb_data`.
- Store byte lanes:
  - SB: `be`=1<<addr[1:0], `wdata`={4{byte}}.
  - SH: `be`=addr[1]?1100:0011, `wdata`={2{half}}.
  - SW: `be`=1111, `wdata`=store_data.
- Loads: `mem_be`=1111. Select the byte/half at addr[1:0]/addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- Reset values: state IDLE, `ready`=1 (follows state), all other outputs 0.
- Reset mid-ACCESS aborts the access. `mem_req` drops immediately and no `wb_valid` is produced.

## Timing
- Accept at edge N. `mem_req` is high from cycle N+1 (registered outputs); `ready`=0 from N+1.
- `mem_ack` sampled at edge M (M≥N+1). `wb_valid` pulses during cycle M+1, `ready`=1 in M+1, and a new access can be accepted at edge M+1.
- Back-to-back minimum: 2 cycles per access (zero-wait memory acks in the first req cycle).
- `mem_ack` outside ACCESS is ignored.
- `wb_data`/`wb_reg` hold their last value after the pulse.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00, is not issued.
  - `misalign_err` pulses in cycle N+1, state stays IDLE, no `wb_valid`.
- Undefined: `misalign_err` is tied 0. Low address bits are ignored for the access width (half uses addr[1], word uses the full word).

## Structure
- Load/store kind encodings (LB…LHU, NOTLOAD, SB/SH/SW, NOTSTORE) and FSM state constants live in the shared define header used by the decoder.
- Sub-module `load_extend`: combinational byte/half select plus sign/zero extension from (`mem_rdata`, addr[1:0], `info_load`).

## Test plan
- SW addr 0x100 data 0xDEADBEEF, ack 2 cycles after `mem_req` → `mem_we`=1, `mem_addr`=0x100, `be`=1111, `wdata`=0xDEADBEEF, no `wb_valid`, `ready` back the cycle after ack.
- SB addr 0x103 data 0x000000A5 → `be`=1000, `wdata`=0xA5A5A5A5, `mem_addr`=0x100.
- LB addr 0x101 rd x5, `rdata`=0x12348056 → `wb_valid` pulse, `wb_reg`=5, `wb_data`=0xFFFFFF80. LBU same → 0x00000080.
- LHU addr 0x102, `rdata`=0x80010000 → `wb_data`=0x00008001. LH → 0xFFFF8001.
- With `LSU_MISALIGN_TRAP_EN`, LW addr 0x102 → `misalign_err` one cycle, `mem_req` never asserted, `ready` stays 1.
- Assert `rst_n`=0 during ACCESS before ack → `mem_req` low immediately, ack after release ignored, no `wb_valid`.
